// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared processor constants: hazard FSM state encoding, HALT drain depth, zero register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

    // Hazard controller FSM states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_t;

    // Cycles a HALT needs to travel from ID/EX to MEM/WB
    localparam int DRAIN_CYCLES_DEF = 3;

    // Architectural zero register; never a real hazard source
    localparam logic [3:0] ZERO_REG = 4'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard detect: load in ID/EX writes a register the ID instruction reads.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       i_idex_memread,
    input  logic [3:0] i_idex_rd,
    input  logic [3:0] i_ifid_rs,
    input  logic [3:0] i_ifid_rt,
    output logic       o_lu
);

    logic w_rd_live;
    logic w_src_match;

    // A load to the zero register never produces a value anyone waits for
    always_comb begin
        w_rd_live   = i_idex_rd != ZERO_REG;
        w_src_match = (i_idex_rd == i_ifid_rs) || (i_idex_rd == i_ifid_rt);
        o_lu        = i_idex_memread && w_rd_live && w_src_match;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/bubble generation plus RUN/DRAIN/HALTED control.
// Latency: enables/flush/bubble combinational (zero cycles); halted and stall_cnt from registers.
// Backpressure: dcache stall freezes every stage; load-use and icache stall hold PC and IF/ID.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [3:0]       i_ifid_rs,
    input  logic [3:0]       i_ifid_rt,
    input  logic [3:0]       i_idex_rd,
    input  logic             i_idex_memread,
    input  logic             i_id_branch_taken,
    input  logic             i_id_halt,
    input  logic             i_icache_stall,
    input  logic             i_dcache_stall,
    output logic             o_pc_wen,
    output logic             o_ifid_wen,
    output logic             o_idex_wen,
    output logic             o_exmem_wen,
    output logic             o_memwb_wen,
    output logic             o_ifid_flush,
    output logic             o_idex_bubble,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    hz_state_t        r_state;
    logic [DW-1:0]    r_drain_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_lu;
    logic w_halt_go;

    load_use_detect u_lu (
        .i_idex_memread (i_idex_memread),
        .i_idex_rd      (i_idex_rd),
        .i_ifid_rs      (i_ifid_rs),
        .i_ifid_rt      (i_ifid_rt),
        .o_lu           (w_lu)
    );

    // Enable/flush/bubble decode; priority dcache > load-use > icache > halt/branch > normal
    always_comb begin
        o_pc_wen      = 1'b0;
        o_ifid_wen    = 1'b0;
        o_idex_wen    = 1'b0;
        o_exmem_wen   = 1'b0;
        o_memwb_wen   = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_halted      = 1'b0;
        w_halt_go     = 1'b0;
        if (i_rst_n) begin
            unique case (r_state)
                ST_RUN: begin
                    if (i_dcache_stall) begin
                        // whole pipeline frozen, all defaults stand
                    end else if (w_lu || i_icache_stall) begin
                        // hold PC and IF/ID, push a bubble behind the stalled instruction
                        o_idex_wen    = 1'b1;
                        o_exmem_wen   = 1'b1;
                        o_memwb_wen   = 1'b1;
                        o_idex_bubble = 1'b1;
                    end else begin
                        o_pc_wen    = 1'b1;
                        o_ifid_wen  = 1'b1;
                        o_idex_wen  = 1'b1;
                        o_exmem_wen = 1'b1;
                        o_memwb_wen = 1'b1;
                        if (i_id_halt) begin
                            // HALT moves into ID/EX, nothing new is fetched behind it
                            o_pc_wen     = 1'b0;
                            o_ifid_flush = 1'b1;
                            w_halt_go    = 1'b1;
                        end else if (i_id_branch_taken) begin
                            o_ifid_flush = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!i_dcache_stall) begin
                        o_idex_wen    = 1'b1;
                        o_exmem_wen   = 1'b1;
                        o_memwb_wen   = 1'b1;
                        o_idex_bubble = 1'b1;
                    end
                end
                ST_HALTED: begin
                    o_halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_stall_cnt = i_rst_n ? r_stall_cnt : '0;

    // FSM, HALT drain countdown and saturating RUN stall counter
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (!o_pc_wen && (r_stall_cnt != '1)) begin
                        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                    end
                    if (w_halt_go) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= DW'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    if (!i_dcache_stall) begin
                        r_drain_cnt <= r_drain_cnt - DW'(1);
                        if (r_drain_cnt == DW'(1)) begin
                            r_state <= ST_HALTED;
                        end
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
